// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: latches request edges, priority-encodes pending unmasked lines, presents index over valid/ready
// Optional feature macro: IRQ_PRIORITY_ENCODER_OVERFLOW_EN (adds per-line overflow status output)
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   req        level request lines, edge-detected internally
//   mask_wdata new mask value, bit=1 enables the line
//   mask_we    mask write enable
//   out_valid  index presented
//   out_index  binary index of the selected line, lowest index wins
//   out_ready  consumer accepts when out_valid && out_ready
//   pending    pending register for status reads
//   mask       mask register
//   overflow   (macro only) repeated edge seen on an already-pending line
module irq_priority_encoder #(
    parameter int SIZE = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2**SIZE-1:0]   req,
    input  logic [2**SIZE-1:0]   mask_wdata,
    input  logic                 mask_we,
    output logic                 out_valid,
    output logic [SIZE-1:0]      out_index,
    input  logic                 out_ready,
    output logic [2**SIZE-1:0]   pending,
    output logic [2**SIZE-1:0]   mask
`ifdef IRQ_PRIORITY_ENCODER_OVERFLOW_EN
    ,
    output logic [2**SIZE-1:0]   overflow
`endif
);
    localparam int W = 2**SIZE;
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;
    logic [0:0]      state;
    logic [W-1:0]    prev_req;
    logic [W-1:0]    rise;
    logic [W-1:0]    clr;
    logic [W-1:0]    cand;
    logic [SIZE-1:0] sel;
    logic            accept;
    assign rise   = req & ~prev_req;
    assign cand   = pending & mask;
    assign accept = out_valid & out_ready;
    always_comb begin
        clr = '0;
        clr[out_index] = accept;
    end
    // Descending scan so the lowest set index is the last assignment and wins.
    always_comb begin
        sel = '0;
        for (int i = W - 1; i >= 0; i--)
            if (cand[i]) sel = SIZE'(i);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_req <= '0;
            pending  <= '0;
            mask     <= '0;
        end else begin
            prev_req <= req;
            pending  <= rise | (pending & ~clr);
            mask     <= mask_we ? mask_wdata : mask;
        end
    end
    // Once presented, the index is held until accepted: no pre-emption, no withdrawal on mask change.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_index <= '0;
        end else if (state == IDLE) begin
            if (|cand) begin
                state     <= PRESENT;
                out_valid <= 1'b1;
                out_index <= sel;
            end
        end else if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end
`ifdef IRQ_PRIORITY_ENCODER_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (!reset_n) overflow <= '0;
        else          overflow <= (rise & pending & ~clr) | (overflow & ~clr);
    end
`else
    // Repeated edges on a pending line merge into the single pending bit.
`endif
endmodule

// File: tb/tb_irq_priority_encoder.sv
// tb_irq_priority_encoder: directed vectors, expected indices queued and checked by a handshake monitor
module tb_irq_priority_encoder;
    localparam int SIZE = 3;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] req;
    logic [7:0] mask_wdata;
    logic       mask_we;
    logic       out_valid;
    logic [2:0] out_index;
    logic       out_ready;
    logic [7:0] pending;
    logic [7:0] mask;
`ifdef IRQ_PRIORITY_ENCODER_OVERFLOW_EN
    logic [7:0] overflow;
`endif
    int pass_cnt = 0;
    int total_cnt = 0;
    logic [2:0] exp_q[$];

    irq_priority_encoder #(.SIZE(SIZE)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .mask_wdata(mask_wdata),
        .mask_we(mask_we),
        .out_valid(out_valid),
        .out_index(out_index),
        .out_ready(out_ready),
        .pending(pending),
        .mask(mask)
`ifdef IRQ_PRIORITY_ENCODER_OVERFLOW_EN
        ,
        .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_handshake", {29'd0, out_index}, 32'hFFFF_FFFF);
            else chk("handshake_index", {29'd0, out_index}, {29'd0, exp_q.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; req = '0; mask_wdata = '0; mask_we = 1'b0; out_ready = 1'b0;
        tick(); tick(); tick();
        neg();
        chk("rst_pending", pending, 0);
        chk("rst_mask", mask, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_index", out_index, 0);
        reset_n = 1'b1;
        tick();
        // test 1: single request, latency and handshake
        mask_wdata = 8'hFF; mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
        neg(); chk("t1_mask", mask, 8'hFF);
        req = 8'h20;
        tick();
        req = 8'h00;
        neg(); chk("t1_pending", pending, 8'h20); chk("t1_valid_early", out_valid, 0);
        tick();
        exp_q.push_back(3'd5); out_ready = 1'b1;
        neg(); chk("t1_valid", out_valid, 1); chk("t1_index", out_index, 5);
        tick();
        out_ready = 1'b0;
        neg(); chk("t1_pending_clr", pending, 0); chk("t1_valid_clr", out_valid, 0);
        // test 2: simultaneous 2 and 6, ready tied high
        exp_q.push_back(3'd2); exp_q.push_back(3'd6); out_ready = 1'b1;
        req = 8'h44;
        tick();
        req = 8'h00;
        neg(); chk("t2_pending", pending, 8'h44); chk("t2_valid0", out_valid, 0);
        tick(); neg(); chk("t2_valid_a", out_valid, 1); chk("t2_index_a", out_index, 2);
        tick(); neg(); chk("t2_gap", out_valid, 0); chk("t2_pending_b", pending, 8'h40);
        tick(); neg(); chk("t2_valid_b", out_valid, 1); chk("t2_index_b", out_index, 6);
        tick(); neg(); chk("t2_done", out_valid, 0); chk("t2_pending_done", pending, 0);
        out_ready = 1'b0;
        // test 3: no pre-emption by higher priority arrival
        exp_q.push_back(3'd4); exp_q.push_back(3'd0);
        req = 8'h10;
        tick();
        req = 8'h00;
        tick(); neg(); chk("t3_index4", out_index, 4);
        req = 8'h01;
        tick();
        req = 8'h00;
        neg(); chk("t3_pending", pending, 8'h11);
        tick(); neg(); chk("t3_hold_valid", out_valid, 1); chk("t3_hold_index", out_index, 4);
        out_ready = 1'b1;
        tick(); neg(); chk("t3_gap", out_valid, 0);
        tick(); neg(); chk("t3_valid0", out_valid, 1); chk("t3_index0", out_index, 0);
        tick(); neg(); chk("t3_done", out_valid, 0);
        out_ready = 1'b0;
        // test 4: masked line stays pending, unmask makes it selectable
        mask_wdata = 8'h00; mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
        req = 8'h08;
        tick();
        req = 8'h00;
        tick(); tick();
        neg(); chk("t4_pending", pending, 8'h08); chk("t4_masked_valid", out_valid, 0);
        exp_q.push_back(3'd3);
        mask_wdata = 8'h08; mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
        neg(); chk("t4_mask", mask, 8'h08); chk("t4_valid_wait", out_valid, 0);
        tick(); neg(); chk("t4_valid", out_valid, 1); chk("t4_index", out_index, 3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        neg(); chk("t4_pending_clr", pending, 0);
        mask_wdata = 8'hFF; mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
        // test 5: new edge during acceptance keeps line pending
        exp_q.push_back(3'd1); exp_q.push_back(3'd1);
        req = 8'h02;
        tick();
        req = 8'h00;
        tick(); neg(); chk("t5_index1", out_index, 1);
        req = 8'h02; out_ready = 1'b1;
        tick();
        req = 8'h00;
        neg(); chk("t5_pending_kept", pending, 8'h02); chk("t5_gap", out_valid, 0);
        tick(); neg(); chk("t5_valid_again", out_valid, 1); chk("t5_index_again", out_index, 1);
        tick();
        out_ready = 1'b0;
        neg(); chk("t5_pending_clr", pending, 0); chk("t5_done", out_valid, 0);
`ifdef IRQ_PRIORITY_ENCODER_OVERFLOW_EN
        exp_q.push_back(3'd7);
        req = 8'h80;
        tick();
        req = 8'h00;
        tick(); neg(); chk("t5_ovf_none", overflow, 0);
        req = 8'h80;
        tick();
        req = 8'h00;
        neg(); chk("t5_ovf_set", overflow, 8'h80);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        neg(); chk("t5_ovf_clr", overflow, 0); chk("t5_ovf_pending", pending, 0);
`endif
        // test 6: request held through reset release, then reset mid-present
        req = 8'h04; reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        neg(); chk("t6_pending", pending, 8'h04); chk("t6_mask_rst", mask, 0); chk("t6_valid", out_valid, 0);
        mask_wdata = 8'hFF; mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
        neg(); chk("t6_single_edge", pending, 8'h04);
        req = 8'h00;
        tick(); neg(); chk("t6_present", out_valid, 1); chk("t6_present_idx", out_index, 2);
        reset_n = 1'b0;
        tick();
        neg();
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_index", out_index, 0);
        chk("t6_rst_pending", pending, 0);
        chk("t6_rst_mask", mask, 0);
        reset_n = 1'b1;
        tick(); tick();
        neg(); chk("t6_idle", out_valid, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
